// File: rtl/fsk_pkg.sv
// Shared defaults and LUT generation for the 2FSK modulator.
// sine_val() is a pure-integer constant function so the sine table can be
// built at elaboration time without real arithmetic in the RTL.
package fsk_pkg;

  localparam int PHASE_W_DFLT = 24;
  localparam int LUT_AW_DFLT  = 8;
  localparam int DATA_W_DFLT  = 8;
  localparam int SPS_DFLT     = 256;

  localparam logic [23:0] FTW0_DFLT = 24'h020000;
  localparam logic [23:0] FTW1_DFLT = 24'h040000;

  // Offset-binary zero for the default sample width.
  localparam logic [7:0] MIDSCALE = 8'h80;

  // LUT[k] = round((2^(dw-1)-0.5) * (1 + sin(2*pi*k/2^aw))), clipped.
  // Works in Q30 fixed point: the angle is folded into the first quadrant,
  // sin() comes from a 15th-order Taylor series, and the result is rounded
  // half-up so that sin=0 lands exactly on midscale.
  function automatic int sine_val(input int k, input int aw, input int dw);
    longint one_q;
    longint pi_q;
    longint kk;
    longint quarter;
    longint quad;
    longint r;
    longint theta;
    longint term;
    longint sum;
    longint amp;
    longint num;
    longint res;
    one_q   = 64'sd1 << 30;
    pi_q    = 64'sd3373259426;           // pi * 2^30
    kk      = longint'(k);
    quarter = (64'sd1 <<< longint'(aw)) / 64'sd4;
    quad    = (kk / quarter) % 64'sd4;
    r       = kk % quarter;
    // Second and fourth quadrants mirror about pi/2.
    if ((quad == 64'sd1) || (quad == 64'sd3)) begin
      r = quarter - r;
    end else begin
      r = r;
    end
    theta = (pi_q * r) / (64'sd2 * quarter);
    sum   = theta;
    term  = theta;
    for (longint n = 64'sd1; n <= 64'sd7; n++) begin
      term = (term * theta) >>> 30;
      term = (term * theta) >>> 30;
      term = -(term / ((64'sd2 * n) * (64'sd2 * n + 64'sd1)));
      sum  = sum + term;
    end
    // Lower half-cycle is the negative image of the upper one.
    if (quad >= 64'sd2) begin
      sum = -sum;
    end else begin
      sum = sum;
    end
    amp = (64'sd1 <<< longint'(dw)) - 64'sd1;
    num = amp * (one_q + sum) + one_q;
    res = num / (64'sd2 * one_q);
    if (res < 64'sd0) begin
      res = 64'sd0;
    end else if (res > amp) begin
      res = amp;
    end else begin
      res = res;
    end
    return int'(res);
  endfunction

endpackage

// File: rtl/fsk_modulator_if.sv
// Signal bundle between the modulator, its code source and the DAC side.
// slave  : the modulator itself.
// master : whoever drives enable/code and consumes the sample stream.
interface fsk_modulator_if #(
  parameter int DATA_W = 8
) ();

  logic              enable;
  logic              code;
  logic              bit_req;
  logic              sym_tick;
  logic              cur_bit;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  modport slave (
    input  enable,
    input  code,
    output bit_req,
    output sym_tick,
    output cur_bit,
    output dout,
    output dout_valid
  );

  modport master (
    output enable,
    output code,
    input  bit_req,
    input  sym_tick,
    input  cur_bit,
    input  dout,
    input  dout_valid
  );

endinterface

// File: rtl/fsk_sine_rom.sv
// Registered full-cycle sine ROM, unsigned offset-binary output.
// Contents are fixed at elaboration from fsk_pkg::sine_val(). The output
// register only advances when en is high so the pipeline can be frozen.
module fsk_sine_rom
  import fsk_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 2 ** LUT_AW;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] lut_s [DEPTH];
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_lut
    localparam int VAL = sine_val(i, LUT_AW, DATA_W);
    assign lut_s[i] = VAL[DATA_W-1:0];
  end

  // Next ROM output: look up when enabled, otherwise keep the last sample.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = lut_s[addr];
    end else begin
      q_d = q_q;
    end
  end

  // ROM output register, resets to midscale.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= MID;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fsk_modulator.sv
// 2FSK modulator: pulls one code bit per symbol from the serial source,
// selects a tuning word from it and runs a phase accumulator through a
// registered sine ROM to produce an unsigned DAC sample stream.
//
// Build option:
//   FSK_PHASE_RESET_EN  when defined, the accumulator restarts from phase 0
//                       at the first clock of every symbol. When undefined
//                       (default) the modulator is continuous-phase.
//
// Timing: phase -> rom_q -> dout is two enabled edges. bit_req is the only
// combinational output; it comes from registered state and enable, so the
// source (which updates on the falling edge) sees a settled request.
module fsk_modulator
  import fsk_pkg::*;
#(
  parameter int                 PHASE_W = PHASE_W_DFLT,
  parameter int                 LUT_AW  = LUT_AW_DFLT,
  parameter int                 DATA_W  = DATA_W_DFLT,
  parameter int                 SPS     = SPS_DFLT,
  parameter logic [PHASE_W-1:0] FTW0    = FTW0_DFLT,
  parameter logic [PHASE_W-1:0] FTW1    = FTW1_DFLT
) (
  input logic            clk,
  input logic            rst,
  fsk_modulator_if.slave bus
);

  localparam int CNT_W = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};

  // Symbol timing and bit capture.
  logic [CNT_W-1:0]   sym_cnt_d;
  logic [CNT_W-1:0]   sym_cnt_q;
  logic               cur_bit_d;
  logic               cur_bit_q;
  logic               sym_tick_d;
  logic               sym_tick_q;

  // Accumulator and sample pipeline.
  logic [PHASE_W-1:0] phase_d;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] ftw_s;
  logic [LUT_AW-1:0]  rom_addr_s;
  logic [DATA_W-1:0]  rom_q_s;
  logic [DATA_W-1:0]  dout_d;
  logic [DATA_W-1:0]  dout_q;
  logic [1:0]         vld_d;
  logic [1:0]         vld_q;

  logic               sym_start_s;
  logic               sym_end_s;

  assign sym_start_s = (sym_cnt_q == CNT_ZERO);
  assign sym_end_s   = (sym_cnt_q == CNT_MAX);
  assign ftw_s       = cur_bit_q ? FTW1 : FTW0;
  assign rom_addr_s  = phase_q[PHASE_W-1 -: LUT_AW];

  // Symbol counter, bit capture and tick; everything holds while disabled.
  always_comb begin
    sym_cnt_d  = sym_cnt_q;
    cur_bit_d  = cur_bit_q;
    sym_tick_d = 1'b0;
    if (bus.enable) begin
      if (sym_end_s) begin
        sym_cnt_d = CNT_ZERO;
      end else begin
        sym_cnt_d = sym_cnt_q + CNT_ONE;
      end
      if (sym_start_s) begin
        cur_bit_d  = bus.code;
        sym_tick_d = 1'b1;
      end else begin
        cur_bit_d  = cur_bit_q;
        sym_tick_d = 1'b0;
      end
    end else begin
      sym_cnt_d  = sym_cnt_q;
      cur_bit_d  = cur_bit_q;
      sym_tick_d = 1'b0;
    end
  end

  // Phase accumulator: free-running wrap, increment follows the registered bit
  // so a new bit steers the frequency one edge after its sym_tick.
  always_comb begin
    phase_d = phase_q;
    if (bus.enable) begin
`ifdef FSK_PHASE_RESET_EN
      if (sym_start_s) begin
        phase_d = {PHASE_W{1'b0}};
      end else begin
        phase_d = phase_q + ftw_s;
      end
`else
      phase_d = phase_q + ftw_s;
`endif
    end else begin
      phase_d = phase_q;
    end
  end

  // Valid pipe tracks enable through the two datapath stages; the DAC
  // register only takes a ROM sample that was itself produced while enabled.
  always_comb begin
    vld_d  = {vld_q[0], bus.enable};
    dout_d = dout_q;
    if (bus.enable && vld_q[0]) begin
      dout_d = rom_q_s;
    end else begin
      dout_d = dout_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q  <= CNT_ZERO;
      cur_bit_q  <= 1'b0;
      sym_tick_q <= 1'b0;
      phase_q    <= {PHASE_W{1'b0}};
      dout_q     <= MID;
      vld_q      <= 2'b00;
    end else begin
      sym_cnt_q  <= sym_cnt_d;
      cur_bit_q  <= cur_bit_d;
      sym_tick_q <= sym_tick_d;
      phase_q    <= phase_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
    end
  end

  fsk_sine_rom #(
    .LUT_AW (LUT_AW),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.enable),
    .addr (rom_addr_s),
    .q    (rom_q_s)
  );

  assign bus.bit_req    = bus.enable & sym_end_s;
  assign bus.sym_tick   = sym_tick_q;
  assign bus.cur_bit    = cur_bit_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q[1];

endmodule

// File: tb/tb_fsk_modulator.sv
// Self-checking bench for fsk_modulator (default parameters).
// A behavioural model built from the symbol/phase/sine rules predicts every
// output each cycle; directed literal checks pin reset, start-up, pause and
// reset-pulse behaviour and the sine table itself.
module tb_fsk_modulator;
  import fsk_pkg::*;

  localparam int     SPS        = 256;
  localparam longint PMOD       = 64'd1 << 24;
  localparam longint M_FTW0     = 64'h020000;
  localparam longint M_FTW1     = 64'h040000;
  localparam int     STEP_BOUND = 13;

  logic clk;
  logic rst;
  fsk_modulator_if #(.DATA_W(8)) bus ();

  fsk_modulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int     m_n     = 0;
  longint m_phase = 0;
  logic   m_bit   = 1'b0;
  logic   m_tick  = 1'b0;
  logic   m_v1    = 1'b0;
  logic   m_v2    = 1'b0;
  int     m_rom   = 128;
  int     m_dout  = 128;

  // Side checks
  int   cnt_en     = 0;
  bit   have_prev  = 1'b0;
  bit   src_mode   = 1'b0;
  bit   chk_toggle = 1'b0;
  bit   have_last  = 1'b0;
  logic last_bit   = 1'b0;
  logic src_bit    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sine_ref(input longint k);
    real a;
    real v;
    int  r;
    a = 2.0 * 3.14159265358979 * real'(k) / 256.0;
    v = 127.5 * (1.0 + $sin(a));
    r = int'($floor(v + 0.5));
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: advances on each rising edge from the bench inputs.
  initial begin
    int   pos;
    logic nv1;
    logic nv2;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_n = 0; m_phase = 0; m_bit = 1'b0; m_tick = 1'b0;
        m_v1 = 1'b0; m_v2 = 1'b0; m_rom = 128; m_dout = 128;
        have_prev = 1'b0; cnt_en = 0;
      end else begin
        nv1 = bus.enable;
        nv2 = m_v1;
        if (bus.enable) begin
          cnt_en++;
          pos = m_n % SPS;
          if (m_v1) m_dout = m_rom;
          m_rom = sine_ref(m_phase >> 16);
`ifdef FSK_PHASE_RESET_EN
          if (pos == 0) m_phase = 0;
          else m_phase = (m_phase + (m_bit ? M_FTW1 : M_FTW0)) % PMOD;
`else
          m_phase = (m_phase + (m_bit ? M_FTW1 : M_FTW0)) % PMOD;
`endif
          if (pos == 0) begin
            m_bit  = bus.code;
            m_tick = 1'b1;
          end else begin
            m_tick = 1'b0;
          end
          m_n++;
        end else begin
          m_tick = 1'b0;
        end
        m_v1 = nv1;
        m_v2 = nv2;
      end
    end
  end

  // Code source: answers each bit request on the falling edge.
  initial begin
    bus.code = 1'b0;
    forever begin
      @(negedge clk);
      if (src_mode && bus.bit_req) begin
        src_bit  = ~src_bit;
        bus.code = src_bit;
      end
    end
  end

  // Compare process: every falling edge, DUT against model and side rules.
  initial begin
    logic prev_valid;
    int   prev_dout;
    int   diff;
    logic exp_b;
    logic exp_req;
    logic tick_d1;
    logic tick_d2;
    prev_valid = 1'b0;
    prev_dout  = 0;
    tick_d1    = 1'b0;
    tick_d2    = 1'b0;
    forever begin
      @(negedge clk);
      exp_req = bus.enable && ((m_n % SPS) == (SPS - 1));
      chk("dout", bus.dout, m_dout);
      chk("dout_valid", bus.dout_valid, m_v2);
      chk("sym_tick", bus.sym_tick, m_tick);
      chk("cur_bit", bus.cur_bit, m_bit);
      chk("bit_req", bus.bit_req, exp_req);
      if (bus.dout_valid && prev_valid) begin
        diff = int'(bus.dout) - prev_dout;
        if (diff < 0) diff = -diff;
        n_cmp++;
        if (diff > STEP_BOUND) begin
          n_bad++;
          $display("FAIL slope: step %0d exceeds bound %0d (t=%0t)", diff, STEP_BOUND, $time);
        end
      end
      if (bus.sym_tick) begin
        if (have_prev) chk("tick_span", cnt_en, SPS);
        cnt_en    = 0;
        have_prev = 1'b1;
        if (chk_toggle) begin
          if (have_last) begin
            exp_b = ~last_bit;
            chk("bit_toggle", bus.cur_bit, exp_b);
          end
          last_bit  = bus.cur_bit;
          have_last = 1'b1;
        end
      end
`ifdef FSK_PHASE_RESET_EN
      if (tick_d2) chk("phase_restart", bus.dout, 8'h80);
`endif
      tick_d2    = tick_d1;
      tick_d1    = bus.sym_tick;
      prev_valid = bus.dout_valid;
      prev_dout  = int'(bus.dout);
    end
  end

  // Directed stimulus
  initial begin
    logic [7:0] samp [128];
    logic [7:0] d0;
    int         vmax;
    int         vmin;
    rst        = 1'b1;
    bus.enable = 1'b1;

    // Sine table pins for the model.
    chk("lut0", sine_ref(0), 128);
    chk("lut32", sine_ref(32), 218);
    chk("lut64", sine_ref(64), 255);
    chk("lut128", sine_ref(128), 128);
    chk("lut192", sine_ref(192), 0);

    // Reset held with enable high.
    step(3);
    chk("rst_dout", bus.dout, MIDSCALE);
    chk("rst_valid", bus.dout_valid, 1'b0);
    chk("rst_tick", bus.sym_tick, 1'b0);
    chk("rst_bitreq", bus.bit_req, 1'b0);
    chk("rst_curbit", bus.cur_bit, 1'b0);

    // Start-up: tick on the first edge, valid after two.
    rst = 1'b0;
    step(1);
    chk("start_tick", bus.sym_tick, 1'b1);
    chk("start_valid1", bus.dout_valid, 1'b0);
    step(1);
    chk("start_valid2", bus.dout_valid, 1'b1);
    chk("start_dout", bus.dout, 8'h80);
    step(10);

    // Code tied 0: 128-clock carrier spanning full scale.
    vmax = 0;
    vmin = 255;
    for (int i = 0; i < 128; i++) begin
      samp[i] = bus.dout;
      if (int'(bus.dout) > vmax) vmax = int'(bus.dout);
      if (int'(bus.dout) < vmin) vmin = int'(bus.dout);
      step(1);
    end
    for (int i = 0; i < 128; i++) begin
      chk("period128", bus.dout, samp[i]);
      step(1);
    end
    chk("carrier_max", vmax, 255);
    chk("carrier_min", vmin, 0);

    // Alternating source bits.
    src_mode   = 1'b1;
    chk_toggle = 1'b1;
    step(4 * SPS + 50);
    chk_toggle = 1'b0;

    // Ten-cycle pause mid-symbol.
    d0         = bus.dout;
    bus.enable = 1'b0;
    step(1);
    chk("pause_hold1", bus.dout, d0);
    chk("pause_valid1", bus.dout_valid, 1'b1);
    step(1);
    chk("pause_hold2", bus.dout, d0);
    chk("pause_valid2", bus.dout_valid, 1'b0);
    step(8);
    chk("pause_hold10", bus.dout, d0);
    bus.enable = 1'b1;
    step(1);
    chk("resume_valid1", bus.dout_valid, 1'b0);
    step(1);
    chk("resume_valid2", bus.dout_valid, 1'b1);
    step(400);

    // One-cycle reset pulse mid-symbol.
    rst = 1'b1;
    step(1);
    chk("pulse_dout", bus.dout, MIDSCALE);
    chk("pulse_valid", bus.dout_valid, 1'b0);
    chk("pulse_tick", bus.sym_tick, 1'b0);
    chk("pulse_curbit", bus.cur_bit, 1'b0);
    chk("pulse_bitreq", bus.bit_req, 1'b0);
    rst = 1'b0;
    step(1);
    chk("pulse_next_tick", bus.sym_tick, 1'b1);
    step(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
